// File: rtl/ball_centroid_collector_pkg.sv
// Shared constants and FSM state encoding for the ball centroid collector.
package ball_centroid_collector_pkg;
  localparam int MAX_BALLS = 7;
  localparam int ID_W      = 3;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } centroid_state_t;
endpackage

// File: rtl/centroid_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
module centroid_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 20
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [DIVIDEND_W-1:0] dividend_in,
  input  logic [DIVISOR_W-1:0]  divisor_in,
  output logic [DIVIDEND_W-1:0] quotient_out,
  output logic                  valid_out,
  output logic                  busy_out
);
  localparam int CW = $clog2(DIVIDEND_W + 1);

  // Handshake: start_in is taken only while busy_out=0 (ignored otherwise);
  // valid_out pulses for one cycle DIVIDEND_W+1 cycles after the accepted
  // start, and quotient_out holds the result until the next start.
  logic [DIVIDEND_W-1:0] quo;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  dsr;
  logic [CW-1:0]         steps;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_next;

  always_comb begin
    shifted  = {rem, quo[DIVIDEND_W-1]};
    ge       = (shifted >= {1'b0, dsr});
    rem_next = ge ? (shifted[DIVISOR_W-1:0] - dsr) : shifted[DIVISOR_W-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      quo       <= '0;
      rem       <= '0;
      dsr       <= '0;
      steps     <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (!busy_out) begin
        if (start_in) begin
          quo      <= dividend_in;
          rem      <= '0;
          dsr      <= divisor_in;
          steps    <= CW'(DIVIDEND_W);
          busy_out <= 1'b1;
        end
      end else begin
        // Dividend bits shift out of quo's top while quotient bits enter at the bottom.
        rem   <= rem_next;
        quo   <= {quo[DIVIDEND_W-2:0], ge};
        steps <= steps - 1'b1;
        if (steps == CW'(1)) begin
          busy_out  <= 1'b0;
          valid_out <= 1'b1;
        end
      end
    end
  end

  assign quotient_out = quo;
endmodule

// File: rtl/ball_centroid_collector.sv
// Per-frame ball pixel accumulation with double-buffered centroid division.
module ball_centroid_collector
  import ball_centroid_collector_pkg::*;
#(
  parameter int MIN_PIXELS = 4,
  parameter int SUM_W      = 32,
  parameter int CNT_W      = 20
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            pixel_valid_in,
  input  logic [ID_W-1:0] ball_id_in,
  input  logic [X_W-1:0]  hcount_in,
  input  logic [Y_W-1:0]  vcount_in,
  input  logic            frame_done_in,
  input  logic [ID_W-1:0] num_balls,
  output logic [X_W-1:0]  real_balls_x [MAX_BALLS-1:0],
  output logic [Y_W-1:0]  real_balls_y [MAX_BALLS-1:0],
  output logic [MAX_BALLS-1:0] ball_found,
  output logic            data_valid_out,
  output logic            busy_out,
  output logic            overrun_out,
  output logic [2:0]      state_dbg
);
  logic [SUM_W-1:0] xsum [MAX_BALLS-1:0];
  logic [SUM_W-1:0] ysum [MAX_BALLS-1:0];
  logic [CNT_W-1:0] cnt  [MAX_BALLS-1:0];
  logic [SUM_W-1:0] xsum_add [MAX_BALLS-1:0];
  logic [SUM_W-1:0] ysum_add [MAX_BALLS-1:0];
  logic [CNT_W-1:0] cnt_add  [MAX_BALLS-1:0];
  logic [SUM_W-1:0] snap_xsum [MAX_BALLS-1:0];
  logic [SUM_W-1:0] snap_ysum [MAX_BALLS-1:0];
  logic [CNT_W-1:0] snap_cnt  [MAX_BALLS-1:0];
  logic [ID_W-1:0]  snap_nb;

  logic [X_W-1:0]       shadow_x [MAX_BALLS-1:0];
  logic [Y_W-1:0]       shadow_y [MAX_BALLS-1:0];
  logic [MAX_BALLS-1:0] shadow_found;

  centroid_state_t state, state_next;
  logic [ID_W-1:0] k;
  logic            slot_active;
  logic            div_start, div_sel_y, div_valid, div_busy;
  logic [SUM_W-1:0] div_dividend, div_quotient;
  logic [CNT_W-1:0] div_divisor;
  logic             div_unused;

  function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  // Ids >= MAX_BALLS match no slot, so they fall through untouched.
  always_comb begin
    for (int i = 0; i < MAX_BALLS; i++) begin
      xsum_add[i] = xsum[i];
      ysum_add[i] = ysum[i];
      cnt_add[i]  = cnt[i];
      if (pixel_valid_in && ball_id_in == ID_W'(i)) begin
        xsum_add[i] = sat_sum(xsum[i], SUM_W'(hcount_in));
        ysum_add[i] = sat_sum(ysum[i], SUM_W'(vcount_in));
        cnt_add[i]  = (cnt[i] == '1) ? cnt[i] : cnt[i] + 1'b1;
      end
    end
  end

  // A pixel in the frame_done cycle is folded into the snapshot, not the new frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < MAX_BALLS; i++) begin
        xsum[i]      <= '0;
        ysum[i]      <= '0;
        cnt[i]       <= '0;
        snap_xsum[i] <= '0;
        snap_ysum[i] <= '0;
        snap_cnt[i]  <= '0;
      end
      snap_nb     <= '0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= frame_done_in && (state != IDLE);
      for (int i = 0; i < MAX_BALLS; i++) begin
        if (frame_done_in) begin
          xsum[i] <= '0;
          ysum[i] <= '0;
          cnt[i]  <= '0;
        end else begin
          xsum[i] <= xsum_add[i];
          ysum[i] <= ysum_add[i];
          cnt[i]  <= cnt_add[i];
        end
        if (frame_done_in && state == IDLE) begin
          snap_xsum[i] <= xsum_add[i];
          snap_ysum[i] <= ysum_add[i];
          snap_cnt[i]  <= cnt_add[i];
        end
      end
      if (frame_done_in && state == IDLE) snap_nb <= num_balls;
    end
  end

  assign slot_active  = (k < snap_nb) && (snap_cnt[k] >= CNT_W'(MIN_PIXELS));
  assign div_dividend = div_sel_y ? snap_ysum[k] : snap_xsum[k];
  assign div_divisor  = snap_cnt[k];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    div_sel_y  = 1'b0;
    case (state)
      IDLE:  if (frame_done_in) state_next = LOAD;
      LOAD: begin
        if (slot_active) begin
          div_start  = 1'b1;
          state_next = DIV_X;
        end else begin
          state_next = NEXT;
        end
      end
      DIV_X: begin
        if (div_valid) begin
          div_start  = 1'b1;
          div_sel_y  = 1'b1;
          state_next = DIV_Y;
        end
      end
      DIV_Y: if (div_valid) state_next = NEXT;
      NEXT:  state_next = (k == ID_W'(MAX_BALLS - 1)) ? DONE : LOAD;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results collect in the shadow bank; the visible outputs move only on entry to DONE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      k              <= '0;
      shadow_found   <= '0;
      ball_found     <= '0;
      data_valid_out <= 1'b0;
      for (int i = 0; i < MAX_BALLS; i++) begin
        shadow_x[i]     <= '0;
        shadow_y[i]     <= '0;
        real_balls_x[i] <= '0;
        real_balls_y[i] <= '0;
      end
    end else begin
      data_valid_out <= (state_next == DONE);
      if (state == IDLE) k <= '0;
      else if (state == NEXT && k != ID_W'(MAX_BALLS - 1)) k <= k + 1'b1;
      if (state == LOAD) shadow_found[k] <= slot_active;
      if (state == DIV_X && div_valid) shadow_x[k] <= div_quotient[X_W-1:0];
      if (state == DIV_Y && div_valid) shadow_y[k] <= div_quotient[Y_W-1:0];
      if (state_next == DONE) begin
        ball_found <= shadow_found;
        for (int i = 0; i < MAX_BALLS; i++) begin
          real_balls_x[i] <= shadow_x[i];
          real_balls_y[i] <= shadow_y[i];
        end
      end
    end
  end

  centroid_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (CNT_W)
  ) u_divider (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (div_start),
    .dividend_in (div_dividend),
    .divisor_in  (div_divisor),
    .quotient_out(div_quotient),
    .valid_out   (div_valid),
    .busy_out    (div_busy)
  );

  assign div_unused = ^{div_quotient[SUM_W-1:X_W], div_busy};
  assign busy_out   = (state != IDLE);
  assign state_dbg  = state;
endmodule

// File: tb/tb_ball_centroid_collector.sv
// Self-checking bench: pixel model + expected-result queue checked on every data_valid_out.
module tb_ball_centroid_collector;
  import ball_centroid_collector_pkg::*;

  localparam int MINP  = 4;
  localparam int EXP_W = MAX_BALLS + MAX_BALLS * X_W + MAX_BALLS * Y_W;
  localparam int XOFF  = MAX_BALLS;
  localparam int YOFF  = MAX_BALLS + MAX_BALLS * X_W;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 pixel_valid_in;
  logic [ID_W-1:0]      ball_id_in;
  logic [X_W-1:0]       hcount_in;
  logic [Y_W-1:0]       vcount_in;
  logic                 frame_done_in;
  logic [ID_W-1:0]      num_balls;
  logic [X_W-1:0]       real_balls_x [MAX_BALLS-1:0];
  logic [Y_W-1:0]       real_balls_y [MAX_BALLS-1:0];
  logic [MAX_BALLS-1:0] ball_found;
  logic                 data_valid_out;
  logic                 busy_out;
  logic                 overrun_out;
  logic [2:0]           state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int fd_cyc = 0;
  logic [EXP_W-1:0] exp_q[$];
  int m_x [MAX_BALLS];
  int m_y [MAX_BALLS];
  int m_c [MAX_BALLS];
  int prev_x [MAX_BALLS];
  int prev_y [MAX_BALLS];

  ball_centroid_collector dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .pixel_valid_in(pixel_valid_in),
    .ball_id_in    (ball_id_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .frame_done_in (frame_done_in),
    .num_balls     (num_balls),
    .real_balls_x  (real_balls_x),
    .real_balls_y  (real_balls_y),
    .ball_found    (ball_found),
    .data_valid_out(data_valid_out),
    .busy_out      (busy_out),
    .overrun_out   (overrun_out),
    .state_dbg     (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe pops one expected result
  always @(negedge clk_in) begin
    if (!rst_in && data_valid_out) begin
      logic [EXP_W-1:0] e;
      n_strobe++;
      strobe_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got strobe %0d, required no strobe", n_strobe);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (ball_found !== e[MAX_BALLS-1:0]) begin
          n_err++;
          $display("FAIL strobe%0d_found: got %b, required %b", n_strobe, ball_found, e[MAX_BALLS-1:0]);
        end
        for (int k = 0; k < MAX_BALLS; k++) begin
          n_cmp++;
          if (real_balls_x[k] !== e[XOFF + X_W*k +: X_W]) begin
            n_err++;
            $display("FAIL strobe%0d_x%0d: got %0d, required %0d", n_strobe, k, real_balls_x[k], e[XOFF + X_W*k +: X_W]);
          end
          n_cmp++;
          if (real_balls_y[k] !== e[YOFF + Y_W*k +: Y_W]) begin
            n_err++;
            $display("FAIL strobe%0d_y%0d: got %0d, required %0d", n_strobe, k, real_balls_y[k], e[YOFF + Y_W*k +: Y_W]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_model();
    for (int k = 0; k < MAX_BALLS; k++) begin
      m_x[k] = 0;
      m_y[k] = 0;
      m_c[k] = 0;
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      pixel_valid_in = 1'b0;
      frame_done_in  = 1'b0;
    end
  endtask

  task automatic drive_pixel(input int id, input int x, input int y);
    @(negedge clk_in);
    frame_done_in  = 1'b0;
    pixel_valid_in = 1'b1;
    ball_id_in     = ID_W'(id);
    hcount_in      = X_W'(x);
    vcount_in      = Y_W'(y);
    if (id < MAX_BALLS) begin
      m_x[id] += x;
      m_y[id] += y;
      m_c[id] += 1;
    end
  endtask

  task automatic frame_end(input string name, input int nb, input bit with_pix,
                           input int id, input int x, input int y, input bit expect_ovr);
    logic [EXP_W-1:0] e;
    @(negedge clk_in);
    frame_done_in  = 1'b1;
    num_balls      = ID_W'(nb);
    pixel_valid_in = with_pix;
    ball_id_in     = ID_W'(id);
    hcount_in      = X_W'(x);
    vcount_in      = Y_W'(y);
    fd_cyc = cyc;
    if (with_pix && id < MAX_BALLS) begin
      m_x[id] += x;
      m_y[id] += y;
      m_c[id] += 1;
    end
    if (!expect_ovr) begin
      e = '0;
      for (int k = 0; k < MAX_BALLS; k++) begin
        if (k < nb && m_c[k] >= MINP) begin
          prev_x[k] = (m_x[k] / m_c[k]) % 2048;
          prev_y[k] = (m_y[k] / m_c[k]) % 1024;
          e[k] = 1'b1;
        end
        e[XOFF + X_W*k +: X_W] = X_W'(prev_x[k]);
        e[YOFF + Y_W*k +: Y_W] = Y_W'(prev_y[k]);
      end
      exp_q.push_back(e);
    end
    clear_model();
    @(negedge clk_in);
    frame_done_in  = 1'b0;
    pixel_valid_in = 1'b0;
    n_cmp++;
    if (overrun_out !== expect_ovr) begin
      n_err++;
      $display("FAIL %s_overrun: got %b, required %b", name, overrun_out, expect_ovr);
    end
    @(negedge clk_in);
    n_cmp++;
    if (overrun_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s_overrun_width: got %b, required 0", name, overrun_out);
    end
  endtask

  task automatic wait_strobe(input string name, input int exp_lat);
    int start;
    int guard;
    start = n_strobe;
    guard = 0;
    while (n_strobe == start && guard < 2000) begin
      @(posedge clk_in);
      guard++;
    end
    n_cmp++;
    if (n_strobe == start) begin
      n_err++;
      $display("FAIL %s_timeout: got no strobe in %0d cycles, required a strobe", name, guard);
    end else if (exp_lat > 0) begin
      n_cmp++;
      if (strobe_cyc - fd_cyc + 1 != exp_lat) begin
        n_err++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, strobe_cyc - fd_cyc + 1, exp_lat);
      end
    end
    @(negedge clk_in);
    n_cmp++;
    if (data_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s_strobe_width: got %b, required 0", name, data_valid_out);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if (ball_found !== '0) begin
      n_err++;
      $display("FAIL %s_found: got %b, required 0", name, ball_found);
    end
    for (int k = 0; k < MAX_BALLS; k++) begin
      n_cmp++;
      if (real_balls_x[k] !== '0 || real_balls_y[k] !== '0) begin
        n_err++;
        $display("FAIL %s_xy%0d: got %0d/%0d, required 0/0", name, k, real_balls_x[k], real_balls_y[k]);
      end
    end
    n_cmp++;
    if ({data_valid_out, busy_out, overrun_out} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_flags: got valid/busy/ovr %b, required 000", name, {data_valid_out, busy_out, overrun_out});
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_in = 1'b1;
    pixel_valid_in = 1'b0;
    ball_id_in = '0;
    hcount_in = '0;
    vcount_in = '0;
    frame_done_in = 1'b0;
    num_balls = '0;
    clear_model();
    for (int k = 0; k < MAX_BALLS; k++) begin
      prev_x[k] = 0;
      prev_y[k] = 0;
    end
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b0;
    drive_idle(2);
    check_all_zero("post_reset");
  endtask

  task automatic test_single();
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        drive_pixel(0, 100 + dx, 50 + dy);
    frame_end("single", 1, 1'b0, 0, 0, 0, 1'b0);
    wait_strobe("single", 1 + 68 + 6 * 2 + 1);
  endtask

  task automatic test_hold_prev();
    drive_pixel(1, 299, 199);
    drive_pixel(1, 301, 201);
    drive_pixel(1, 300, 200);
    drive_pixel(1, 300, 200);
    frame_end("hold_prev", 2, 1'b0, 0, 0, 0, 1'b0);
    wait_strobe("hold_prev", 0);
  endtask

  task automatic test_truncation();
    drive_pixel(2, 10, 20);
    drive_pixel(2, 11, 21);
    drive_pixel(1, 5, 5);
    drive_pixel(2, 10, 20);
    drive_pixel(1, 5, 5);
    drive_pixel(2, 11, 21);
    drive_pixel(1, 5, 5);
    frame_end("truncation", 3, 1'b0, 0, 0, 0, 1'b0);
    wait_strobe("truncation", 0);
  endtask

  task automatic test_ignore_boundary();
    for (int i = 0; i < 3; i++) begin
      drive_pixel(7, 2000, 1000);
      drive_pixel(0, 40, 30);
      drive_pixel(3, 77, 66);
    end
    drive_pixel(3, 77, 66);
    frame_end("boundary", 1, 1'b1, 0, 44, 34, 1'b0);
    wait_strobe("boundary", 0);
  endtask

  task automatic test_overrun();
    drive_pixel(0, 120, 60);
    drive_pixel(0, 122, 62);
    drive_pixel(1, 250, 150);
    drive_pixel(0, 121, 61);
    drive_pixel(1, 250, 150);
    drive_pixel(0, 121, 61);
    drive_pixel(1, 251, 151);
    drive_pixel(1, 251, 151);
    frame_end("overrun_a", 2, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive_pixel(0, 500, 400);
    drive_idle(90);
    frame_end("overrun_drop", 1, 1'b0, 0, 0, 0, 1'b1);
    wait_strobe("overrun_a", 0);
    for (int i = 0; i < 4; i++) drive_pixel(0, 200, 100);
    frame_end("overrun_c", 1, 1'b0, 0, 0, 0, 1'b0);
    wait_strobe("overrun_c", 0);
  endtask

  task automatic test_reset_mid_div();
    int guard;
    int start;
    for (int i = 0; i < 4; i++) begin
      drive_pixel(0, 60, 70);
      drive_pixel(1, 80, 90);
    end
    frame_end("mid_div", 2, 1'b0, 0, 0, 0, 1'b0);
    guard = 0;
    while (state_dbg !== 3'(DIV_Y) && guard < 500) begin
      @(negedge clk_in);
      guard++;
    end
    n_cmp++;
    if (state_dbg !== 3'(DIV_Y)) begin
      n_err++;
      $display("FAIL mid_div_reach: got state %0d, required %0d", state_dbg, 3'(DIV_Y));
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check_all_zero("mid_div_reset");
    exp_q.delete();
    clear_model();
    for (int k = 0; k < MAX_BALLS; k++) begin
      prev_x[k] = 0;
      prev_y[k] = 0;
    end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    start = n_strobe;
    drive_idle(200);
    n_cmp++;
    if (n_strobe != start) begin
      n_err++;
      $display("FAIL mid_div_no_strobe: got %0d strobes, required 0", n_strobe - start);
    end
    drive_pixel(3, 7, 8);
    drive_pixel(3, 9, 10);
    drive_pixel(3, 7, 8);
    drive_pixel(3, 9, 10);
    frame_end("after_reset", 4, 1'b0, 0, 0, 0, 1'b0);
    wait_strobe("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_prev();
    test_truncation();
    test_ignore_boundary();
    test_overrun();
    test_reset_mid_div();
    drive_idle(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
